// File: rtl/multicycle_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, default widths, phase indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_RUN      = 3'd1,
        SEQ_STOPPING = 3'd2,
        SEQ_STEP     = 3'd3,
        SEQ_HALTED   = 3'd4
    } seq_state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_NPHASE = 5;
    localparam int DEF_CNT_W  = 16;

    // Phase indices of the classic five-phase instruction (0-based, P1 = PH_FETCH)
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;

    // States in which the phase ring is allowed to advance
    function automatic logic seq_is_active(seq_state_t s);
        return (s == SEQ_RUN) || (s == SEQ_STOPPING) || (s == SEQ_STEP);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the phase sequencer and the datapath/decode logic.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stalls the sequencer in its memory phase.
interface multicycle_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int NPHASE = 5,
    parameter int CNT_W  = 16
);
    // Commands and feedback into the sequencer
    logic              exec;
    logic              step;
    logic              halt_req;
    logic              mem_req;
    logic              mem_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;

    // Sequencer status out to the datapath
    logic [NPHASE-1:0] phase;
    logic [ADDR_W-1:0] pc;
    logic              ir_load;
    logic              active;
    logic              halted;
    logic              mem_timeout;
    logic              instr_done;
    logic [CNT_W-1:0]  retired;

    // Datapath/control side
    modport master (
        output exec, step, halt_req, mem_req, mem_ready, branch_taken, branch_target,
        input  phase, pc, ir_load, active, halted, mem_timeout, instr_done, retired
    );

    // Sequencer side
    modport slave (
        input  exec, step, halt_req, mem_req, mem_ready, branch_taken, branch_target,
        output phase, pc, ir_load, active, halted, mem_timeout, instr_done, retired
    );

endinterface

// File: rtl/multicycle_sequencer_phase_ring.sv
// One-hot phase rotator: P1 -> P2 -> ... -> PN -> P1, with hold and force-to-P1.
// Latency: one phase step per enabled cycle.
// Backpressure: enable low holds the current phase (memory stall / idle).
module phase_ring #(
    parameter int N = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    output logic [N-1:0] phase
);

    // Rotate left on enable; clear (timeout) and reset both return to P1
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase <= N'(1);
        end else if (enable) begin
            phase <= {phase[N-2:0], phase[N-1]};
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer and PC unit: run/stop/single-step control, memory stalls, sticky halt.
// Latency: NPHASE cycles per instruction plus one per memory wait-state cycle.
// Backpressure: mem_req & ~mem_ready holds the memory phase; WAIT_MAX stalls forces HALTED.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          NPHASE     = DEF_NPHASE,
    parameter int          MEM_PHASE  = PH_MEM,
    parameter int          HALT_PHASE = PH_EXEC,
    parameter int unsigned RESET_PC   = 0,
    parameter int          WAIT_MAX   = 15,
    parameter int          CNT_W      = DEF_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_sequencer_if.slave  bus
);

    localparam int              WAIT_W     = $clog2(WAIT_MAX + 1);
    // Counter value seen during the WAIT_MAX-th consecutive stall cycle
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX - 1);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [NPHASE-1:0] phase;
    logic [ADDR_W-1:0] pc_q;
    logic [WAIT_W-1:0] wait_q;
    logic              halt_pend_q;
    logic              timeout_q;
    logic              done_q;
    logic [CNT_W-1:0]  retired_q;

    logic active;
    logic stall;
    logic timeout_hit;
    logic advance;
    logic last_done;
    logic halt_sample;
    logic halt_now;

    assign active      = seq_is_active(state_q);
    assign stall       = active & phase[MEM_PHASE] & bus.mem_req & ~bus.mem_ready;
    assign timeout_hit = stall & (wait_q == WAIT_LIMIT);
    assign advance     = active & ~stall;
    assign last_done   = advance & phase[NPHASE-1];
    assign halt_sample = active & phase[HALT_PHASE] & bus.halt_req;
    // A halt seen in the same cycle the instruction ends still counts
    assign halt_now    = halt_pend_q | halt_sample;

    phase_ring #(
        .N (NPHASE)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .enable (advance),
        .clear  (timeout_hit),
        .phase  (phase)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: commands act at instruction boundaries, halt outranks stop/step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (bus.exec) begin
                    state_d = SEQ_RUN;
                end else if (bus.step) begin
                    state_d = SEQ_STEP;
                end
            end
            SEQ_RUN: begin
                if (last_done) begin
                    // A stop arriving on the final phase ends the run right here
                    if (halt_now) begin
                        state_d = SEQ_HALTED;
                    end else if (bus.exec) begin
                        state_d = SEQ_IDLE;
                    end
                end else if (bus.exec) begin
                    state_d = SEQ_STOPPING;
                end
            end
            SEQ_STOPPING, SEQ_STEP: begin
                if (last_done) begin
                    state_d = halt_now ? SEQ_HALTED : SEQ_IDLE;
                end
            end
            SEQ_HALTED: begin
                state_d = SEQ_HALTED;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_d = SEQ_HALTED;
        end
    end

    // Halt request is remembered until the instruction that raised it completes
    always_ff @(posedge clock) begin
        if (reset) begin
            halt_pend_q <= 1'b0;
        end else if (last_done || timeout_hit) begin
            halt_pend_q <= 1'b0;
        end else if (halt_sample) begin
            halt_pend_q <= 1'b1;
        end
    end

    // Wait-state counter: counts consecutive stall cycles, clears on any progress
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q <= '0;
        end else if (stall && !timeout_hit) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // PC: advance when fetch phase completes, branch target replaces it at the end
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else if (last_done && bus.branch_taken) begin
            pc_q <= bus.branch_target;
        end else if (advance && phase[0]) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    // Completion pulse, retired count and sticky timeout flag
    always_ff @(posedge clock) begin
        if (reset) begin
            done_q    <= 1'b0;
            retired_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= last_done;
            if (last_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.phase       = phase;
    assign bus.pc          = pc_q;
    assign bus.ir_load     = active & phase[0];
    assign bus.active      = active;
    assign bus.halted      = (state_q == SEQ_HALTED);
    assign bus.mem_timeout = timeout_q;
    assign bus.instr_done  = done_q;
    assign bus.retired     = retired_q;

endmodule
